// File: rtl/cv32e40p_ft_pkg.sv
// cv32e40p_ft_pkg: shared fault-tolerance constants, types and the TMR majority helper.
package cv32e40p_ft_pkg;

   localparam int unsigned FFIFO_DEPTH = 2;
   localparam bit          FFIFO_FT    = 1'b1;

   typedef struct packed {
      logic        par;
      logic [31:0] addr;
      logic [31:0] rdata;
   } ffifo_entry_t;

   function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/cv32e40p_tmr_reg.sv
// cv32e40p_tmr_reg: triplicated register with bitwise majority vote and copy-mismatch flag.
module cv32e40p_tmr_reg
   import cv32e40p_ft_pkg::*;
#(
   parameter int unsigned W   = 1,
   parameter logic [W-1:0] RST = '0,
   parameter bit          TMR = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic         mismatch_o
);

   if (TMR) begin : g_tmr
      logic [2:0][W-1:0] cp_q;
      logic [31:0]       vote;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) cp_q <= {3{RST}};
         else        cp_q <= {3{d_i}};
      end
      assign vote       = majority(32'(cp_q[0]), 32'(cp_q[1]), 32'(cp_q[2]));
      assign q_o        = vote[W-1:0];
      assign mismatch_o = (32'(cp_q[0]) != vote) | (32'(cp_q[1]) != vote) | (32'(cp_q[2]) != vote);
   end else begin : g_plain
      logic [W-1:0] cp_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) cp_q <= RST;
         else        cp_q <= d_i;
      end
      assign q_o        = cp_q;
      assign mismatch_o = 1'b0;
   end

endmodule

// File: rtl/cv32e40p_fetch_fifo_ft.sv
// cv32e40p_fetch_fifo_ft: parity-protected fetch FIFO with TMR pointers/count;
// a corrupted head flushes the FIFO and requests a refetch from its address.
module cv32e40p_fetch_fifo_ft
   import cv32e40p_ft_pkg::*;
#(
   parameter int unsigned DEPTH = FFIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   input  logic [31:0]              in_rdata_i,
   input  logic [31:0]              in_addr_i,
   output logic                     in_ready_o,
   output logic                     out_valid_o,
   output logic [31:0]              out_rdata_o,
   output logic [31:0]              out_addr_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic                     refetch_o,
   output logic [31:0]              refetch_addr_o,
   output logic                     err_detected_o,
   output logic                     err_corrected_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   ffifo_entry_t [DEPTH-1:0] mem_q;
   ffifo_entry_t             head;
   logic [AW-1:0]            rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     m_rd, m_wr, m_cnt;
   logic                     head_err, push, pop, clear;

   cv32e40p_tmr_reg #(.W(AW), .RST('0), .TMR(FFIFO_FT)) u_rd (
      .clk, .rst_n, .d_i(rd_d), .q_o(rd_q), .mismatch_o(m_rd)
   );
   cv32e40p_tmr_reg #(.W(AW), .RST('0), .TMR(FFIFO_FT)) u_wr (
      .clk, .rst_n, .d_i(wr_d), .q_o(wr_q), .mismatch_o(m_wr)
   );
   cv32e40p_tmr_reg #(.W(CW), .RST('0), .TMR(FFIFO_FT)) u_cnt (
      .clk, .rst_n, .d_i(cnt_d), .q_o(cnt_q), .mismatch_o(m_cnt)
   );

   assign head     = mem_q[rd_q];
   assign head_err = FFIFO_FT && (cnt_q != '0) && ((^{head.addr, head.rdata}) != head.par);

   assign in_ready_o  = cnt_q != CW'(DEPTH);
   assign out_valid_o = (cnt_q != '0) & ~head_err & ~flush_i;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;
   assign clear       = flush_i | refetch_o;

   assign out_rdata_o     = head.rdata;
   assign out_addr_o      = head.addr;
   assign cnt_o           = cnt_q;
   assign err_detected_o  = head_err;
   assign refetch_o       = head_err & ~flush_i;
   assign refetch_addr_o  = head.addr;
   assign err_corrected_o = m_rd | m_wr | m_cnt;

   // Flush and refetch both discard any same-cycle push or pop.
   always_comb begin
      rd_d  = clear ? '0 : pop  ? rd_q + AW'(1) : rd_q;
      wr_d  = clear ? '0 : push ? wr_q + AW'(1) : wr_q;
      cnt_d = clear ? '0 : (push & ~pop) ? cnt_q + CW'(1) : (pop & ~push) ? cnt_q - CW'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (push & ~clear)
         mem_q[wr_q] <= '{par: FFIFO_FT ? ^{in_addr_i, in_rdata_i} : 1'b0,
                          addr: in_addr_i, rdata: in_rdata_i};
   end

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ft.sv
// tb_cv32e40p_fetch_fifo_ft: directed and random checks of the fetch FIFO against a queue model.
module tb_cv32e40p_fetch_fifo_ft;

   logic        clk, rst_n, flush_i, in_valid_i, out_ready_i;
   logic [31:0] in_rdata_i, in_addr_i;
   logic        in_ready_o, out_valid_o, refetch_o, err_detected_o, err_corrected_o;
   logic [31:0] out_rdata_o, out_addr_o, refetch_addr_o;
   logic [1:0]  cnt_o;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;

   ent_t             q[$];
   int               n_chk = 0;
   int               n_fail = 0;
   logic [129:0]     mm;
   logic [2:0][0:0]  cp;

   cv32e40p_fetch_fifo_ft #(.DEPTH(2)) dut (
      .clk, .rst_n, .flush_i, .in_valid_i, .in_rdata_i, .in_addr_i, .in_ready_o,
      .out_valid_o, .out_rdata_o, .out_addr_o, .out_ready_i, .cnt_o, .refetch_o,
      .refetch_addr_o, .err_detected_o, .err_corrected_o
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check 1ns later, advance the queue model.
   task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, input bit fl, input bit cor, input bit tmr);
      bit he, ev, rf, pu, po;
      @(negedge clk);
      in_valid_i = v; in_addr_i = a; in_rdata_i = d; out_ready_i = rdy; flush_i = fl;
      if (cor) begin
         mm = dut.mem_q;
         mm = mm ^ {2{65'd1}};
         force dut.mem_q = mm;
      end
      if (tmr) begin
         cp = dut.u_wr.g_tmr.cp_q;
         cp[2] = ~cp[2];
         force dut.u_wr.g_tmr.cp_q = cp;
      end
      #1;
      he = cor && q.size() != 0;
      rf = he && !fl;
      ev = q.size() != 0 && !he && !fl;
      chk("cnt", 32'(cnt_o), q.size());
      chk("in_ready", 32'(in_ready_o), 32'(q.size() != 2));
      chk("out_valid", 32'(out_valid_o), 32'(ev));
      chk("err_detected", 32'(err_detected_o), 32'(he));
      chk("refetch", 32'(refetch_o), 32'(rf));
      chk("err_corrected", 32'(err_corrected_o), 32'(tmr));
      if (ev) begin
         chk("out_rdata", out_rdata_o, q[0].d);
         chk("out_addr", out_addr_o, q[0].a);
      end
      if (rf) chk("refetch_addr", refetch_addr_o, q[0].a);
      if (tmr) release dut.u_wr.g_tmr.cp_q;
      po = ev && rdy;
      pu = v && q.size() < 2;
      if (fl || rf) q.delete();
      else begin
         if (po) void'(q.pop_front());
         if (pu) q.push_back('{a: a, d: d});
      end
      @(posedge clk);
      if (cor) begin
         #1;
         release dut.mem_q;
      end
   endtask

   initial begin
      rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      in_rdata_i = '0; in_addr_i = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0);
      // basic fill to full then drain
      cyc(1, 32'h80, 32'h00000013, 0, 0, 0, 0);
      cyc(1, 32'h84, 32'h00100093, 0, 0, 0, 0);
      cyc(1, 32'h88, 32'hdeadbeef, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // steady push+pop at count 1 across pointer wrap
      cyc(1, 32'h200, 32'h1000, 0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) cyc(1, 32'h200 + 4 * i, 32'h1000 + i, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // corrupted head triggers refetch
      cyc(1, 32'h100, 32'h12345678, 0, 0, 0, 0);
      cyc(1, 32'h300, 32'h0, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // same corruption masked by a flush
      cyc(1, 32'h100, 32'h12345678, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      // upset in one write-pointer copy is out-voted
      cyc(1, 32'h400, 32'haaaa5555, 0, 0, 0, 0);
      cyc(1, 32'h404, 32'h5555aaaa, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 32'h408, 32'h01234567, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      // randomized traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 3) != 0, $urandom & 32'hfffffffc, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
             q.size() != 0 && $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      // asynchronous reset while full
      cyc(1, 32'h500, 32'h11111111, 0, 0, 0, 0);
      cyc(1, 32'h504, 32'h22222222, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_cnt", 32'(cnt_o), 0);
      chk("rst_in_ready", 32'(in_ready_o), 1);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_refetch", 32'(refetch_o), 0);
      chk("rst_err_detected", 32'(err_detected_o), 0);
      chk("rst_err_corrected", 32'(err_corrected_o), 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 32'h600, 32'h33333333, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cv32e40p_fetch_fifo_ft.md
# cv32e40p_fetch_fifo_ft

Fault-tolerant fetch FIFO that buffers fetched instruction words and their addresses between the instruction memory interface and the fault-tolerant aligner stage, which it feeds directly. Each entry is parity-protected. Read/write pointers and the occupancy count are triplicated and majority-voted every cycle. A parity failure on the head entry flushes the FIFO and requests a refetch from the corrupted word's address.

## Interface
- DEPTH, 2: number of entries; power of two, ≥2.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- flush_i  in  1  branch/flush; empties FIFO.
- in_valid_i  in  1  fetched word valid.
- in_rdata_i  in  32  fetched word.
- in_addr_i  in  32  address of fetched word.
- in_ready_o  out  1  FIFO can accept a push.
- out_valid_o  out  1  head entry valid and parity-clean; drives aligner fetch_valid_i.
- out_rdata_o  out  32  head word; drives aligner fetch_rdata_i.
- out_addr_o  out  32  head address.
- out_ready_i  in  1  pop; aligner_ready_o & if_valid from consumer.
- cnt_o  out  $clog2(DEPTH)+1  voted occupancy.
- refetch_o  out  1  one-cycle refetch request.
- refetch_addr_o  out  32  address to refetch; valid while refetch_o=1.
- err_detected_o  out  1  parity error on head this cycle.
- err_corrected_o  out  1  a pointer/count copy disagreed with the vote this cycle.

## Operation
- Entry = {par, addr[31:0], rdata[31:0]}; par = ^{addr, rdata}, written on push. Storage array not reset; validity given only by count.
- rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count each held as three copies. Next state is computed from the bitwise-majority value and written to all three copies, so a single upset is corrected next cycle. err_corrected_o = any copy differs from its vote (combinational).
- head_err = (count≠0) & (recomputed parity of mem[rd_ptr] ≠ par).
- in_ready_o = (count≠DEPTH). push = in_valid_i & in_ready_o.
- out_valid_o = (count≠0) & ~head_err & ~flush_i. pop = out_valid_o & out_ready_i.
- out_rdata_o / out_addr_o = mem[rd_ptr] (combinational; don't-care when out_valid_o=0).
- err_detected_o = head_err. refetch_o = head_err & ~flush_i. refetch_addr_o = mem[rd_ptr].addr.
- Priority, highest first:
  - flush_i: count, rd_ptr and wr_ptr are 0 next cycle; push and pop are ignored.
  - refetch_o: same clear as flush; a push in that cycle is discarded.
  - Otherwise: push only gives count+1; pop only gives count−1; push & pop gives count unchanged with both pointers advancing.
- Full: no push; pop allowed. Push & pop while full is impossible, because in_ready_o=0.
- Empty: out_valid_o=0, err_detected_o=0, refetch_o=0. Push into empty does not bypass.
- Parity error on a non-head entry is not detected until that entry reaches the head.

## Timing
- Reset values: count/pointers 0, in_ready_o 1, out_valid_o 0, cnt_o 0, refetch_o 0, err_detected_o 0, err_corrected_o 0.
- Push at edge N makes the data visible on out_* after edge N (1-cycle latency). No combinational path from in_valid_i to out_valid_o.
- Combinational paths to out_valid_o: flush_i and storage/parity only. out_ready_i does not affect out_valid_o.
- refetch_o lasts exactly one cycle per corrupted head: the FIFO is empty the following cycle.
- Reset asserted mid-operation clears all triplicated state immediately; outputs take their reset values asynchronously.

## Structure
- cv32e40p_ft_pkg adds the following constants:
  - FFIFO_DEPTH (default 2).
  - FFIFO_FT (0 = parity and TMR removed: plain FIFO, err outputs tied 0, refetch_o tied 0).
- Sub-module cv32e40p_tmr_reg, parameterised by width and reset value:
  - holds three copies, outputs the voted value and a mismatch flag;
  - instantiated for rd_ptr, wr_ptr and count.
- Voting reuses the package's existing majority function.

## Test plan
- Reset, then push 0x00000013@0x80, 0x00100093@0x84 → cnt_o=2, in_ready_o=0, out_rdata_o=0x00000013; pop twice → cnt_o=0, in_ready_o=1.
- Simultaneous push/pop at count 1 over 10 cycles with DEPTH=2 → cnt_o stays 1, data order preserved through pointer wrap.
- Force one rdata bit of head entry (addr 0x100) → err_detected_o=1, refetch_o=1 for one cycle with refetch_addr_o=0x100, out_valid_o=0, cnt_o=0 next cycle.
- Same corruption with flush_i=1 in that cycle → refetch_o=0, FIFO empty next cycle.
- Force one copy of wr_ptr to a wrong value → err_corrected_o=1 that cycle, 0 the next, and data flow is unaffected.
- Assert rst_n low mid-stream with cnt_o=2 → all outputs at reset values without waiting for a clock edge.
